// File: rtl/uart_pkg.sv
// Purpose: shared UART frame definitions used by both the receiver and the transmitter.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  // Parity mode. The numeric values match the PARITY parameter of uart_rx/uart_tx.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  // One-hot receiver state encoding.
  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_START  = 6'b000010;
  localparam logic [5:0] ST_DATA   = 6'b000100;
  localparam logic [5:0] ST_PARITY = 6'b001000;
  localparam logic [5:0] ST_STOP   = 6'b010000;
  localparam logic [5:0] ST_BREAK  = 6'b100000;

  // Clock cycles per bit, rounded to nearest so that TX and RX agree on the bit period.
  function automatic int samples_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: generic two-flop synchroniser for asynchronous pin inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running).
// Ports: clk, n_rst (async active-low), d (async input), q (synchronised output, resets to RST_VAL).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver; LSB-first deserialiser with start/parity/stop checking.
// Latency: o_data_valid rises 3 clk cycles after the middle of the last stop bit.
// Backpressure: none; the consumer must take every one-cycle o_data_valid pulse.
// Ports: clk, n_rst (async active-low), i_rx (async serial line, idle high),
//        o_data_valid (1-cycle pulse), o_data, o_parity_err, o_frame_err (held between
//        pulses), o_busy (frame in progress).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_rx,
  output logic                 o_data_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int SPB      = samples_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = SPB / 2;
  localparam int CW       = $clog2(SPB + 1);
  localparam int BW       = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(SPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam parity_t       PAR_MODE  = parity_t'(PARITY[1:0]);

  typedef enum logic [5:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY_S = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_s, rx_s_prev;
  logic [CW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_err_r, frame_err_r;
  logic                 tick, frame_start, frame_done;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (i_rx),
    .q     (rx_s)
  );

  // Previous synchronised level: a start needs a real high-to-low edge, so a line
  // that is already low when reset releases is not mistaken for a frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rx_s_prev <= 1'b1;
    else        rx_s_prev <= rx_s;
  end

  // Counter is restarted on entry to each state, so a tick lands one full bit
  // after the mid-start check, i.e. in the middle of every following bit.
  assign tick = (sample_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s && rx_s_prev) begin
          state_nxt   = START;
          frame_start = 1'b1;
        end
      end
      START: begin
        // Line back high at mid-start means a glitch: drop it silently.
        if (sample_cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && bit_cnt == DATA_LAST)
          state_nxt = (PAR_MODE == PARITY_NONE) ? STOP : PARITY_S;
      end
      PARITY_S: begin
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a start edge right after the stop bit is caught.
        if (tick && bit_cnt == STOP_LAST) begin
          frame_done = 1'b1;
          state_nxt  = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else if (state_nxt != state) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      if (state == START || state == DATA || state == PARITY_S || state == STOP)
        sample_cnt <= tick ? '0 : sample_cnt + CW'(1);
      if ((state == DATA || state == STOP) && tick)
        bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r      <= '0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      if (frame_start) begin
        parity_err_r <= 1'b0;
        frame_err_r  <= 1'b0;
      end
      // Right shift with MSB insert leaves the first received bit in bit 0.
      if (state == DATA && tick)
        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      if (state == PARITY_S && tick)
        parity_err_r <= ((^shift_r) ^ rx_s) != (PAR_MODE == PARITY_ODD);
      if (state == STOP && tick && !rx_s)
        frame_err_r <= 1'b1;
    end
  end

  // The last stop sample is folded in directly since frame_err_r only sees it next cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= frame_done;
      if (frame_done) begin
        o_data       <= shift_r;
        o_parity_err <= parity_err_r;
        o_frame_err  <= frame_err_r | ~rx_s;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed self-checking bench for uart_rx (8N1 and 8E1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int SPB = 434;

  logic       clk;
  logic       n_rst;
  logic       rx0, rx1;
  logic       dv0, dv1;
  logic [7:0] data0, data1;
  logic       pe0, pe1, fe0, fe1, busy0, busy1;

  int checks   = 0;
  int failures = 0;
  int busy_cyc0 = 0;

  // Captured pulses: {frame_err, parity_err, data}
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .i_rx(rx0), .o_data_valid(dv0), .o_data(data0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(busy0)
  );

  uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .i_rx(rx1), .o_data_valid(dv1), .o_data(data1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv0) q0.push_back({fe0, pe0, data0});
    if (dv1) q1.push_back({fe1, pe1, data1});
    if (busy0) busy_cyc0 = busy_cyc0 + 1;
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int sel, input logic v);
    drive(sel, v);
    wait_clk(SPB);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input int has_par,
                            input logic pbit, input logic stop_v);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (has_par != 0) send_bit(sel, pbit);
    send_bit(sel, stop_v);
    drive(sel, 1'b1);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    wait_clk(5);
    checks++;
    if ({dv0, data0, pe0, fe0, busy0} !== 12'h000) begin
      failures++;
      $display("FAIL reset_out0 got=%h exp=000", {dv0, data0, pe0, fe0, busy0});
    end
    checks++;
    if ({dv1, data1, pe1, fe1, busy1} !== 12'h000) begin
      failures++;
      $display("FAIL reset_out1 got=%h exp=000", {dv1, data1, pe1, fe1, busy1});
    end
    n_rst = 1'b1;
    wait_clk(10);
  endtask

  task automatic test_frame_a5;
    int b0;
    logic [9:0] e;
    b0 = busy_cyc0;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    wait_clk(20);
    checks++;
    if (q0.size() !== 1) begin
      failures++;
      $display("FAIL a5_pulses got=%0d exp=1", q0.size());
    end
    e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b00, 8'hA5}) begin
      failures++;
      $display("FAIL a5_word got=%h exp=%h", e, {2'b00, 8'hA5});
    end
    // 217 (half start) + 8*434 (data) + 434 (to mid-stop) cycles busy
    checks++;
    if ((busy_cyc0 - b0) < 4120 || (busy_cyc0 - b0) > 4126) begin
      failures++;
      $display("FAIL a5_busy_len got=%0d exp=4123", busy_cyc0 - b0);
    end
    wait_clk(100);
    checks++;
    if ({busy0, data0} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL a5_hold got=%h exp=%h", {busy0, data0}, {1'b0, 8'hA5});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d[3];
    logic [9:0] e;
    exp_d[0] = 8'h00;
    exp_d[1] = 8'hFF;
    exp_d[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(0, exp_d[i], 0, 1'b0, 1'b1);
    wait_clk(20);
    checks++;
    if (q0.size() !== 3) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=3", q0.size());
    end
    for (int i = 0; i < 3; i++) begin
      e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
      checks++;
      if (e !== {2'b00, exp_d[i]}) begin
        failures++;
        $display("FAIL b2b_word%0d got=%h exp=%h", i, e, {2'b00, exp_d[i]});
      end
    end
  endtask

  task automatic test_parity;
    logic [9:0] e;
    // 0x07 has three ones: even parity bit must be 1
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    wait_clk(20);
    checks++;
    if (q1.size() !== 1) begin
      failures++;
      $display("FAIL par_bad_pulses got=%0d exp=1", q1.size());
    end
    e = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b01, 8'h07}) begin
      failures++;
      $display("FAIL par_bad_word got=%h exp=%h", e, {2'b01, 8'h07});
    end
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    wait_clk(20);
    checks++;
    if (q1.size() !== 1) begin
      failures++;
      $display("FAIL par_good_pulses got=%0d exp=1", q1.size());
    end
    e = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b00, 8'h07}) begin
      failures++;
      $display("FAIL par_good_word got=%h exp=%h", e, {2'b00, 8'h07});
    end
  endtask

  task automatic test_glitch;
    drive(0, 1'b0);
    wait_clk(100);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_mid got=%b exp=1", busy0);
    end
    wait_clk(100);
    drive(0, 1'b1);
    wait_clk(200);
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy_end got=%b exp=0", busy0);
    end
    checks++;
    if (q0.size() !== 0) begin
      failures++;
      $display("FAIL glitch_pulses got=%0d exp=0", q0.size());
    end
  endtask

  task automatic test_break;
    logic [9:0] e;
    drive(0, 1'b0);
    wait_clk(20 * SPB);
    checks++;
    if (busy0 !== 1'b1) begin
      failures++;
      $display("FAIL break_busy_low got=%b exp=1", busy0);
    end
    checks++;
    if (q0.size() !== 1) begin
      failures++;
      $display("FAIL break_pulses got=%0d exp=1", q0.size());
    end
    e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b10, 8'h00}) begin
      failures++;
      $display("FAIL break_word got=%h exp=%h", e, {2'b10, 8'h00});
    end
    drive(0, 1'b1);
    wait_clk(20);
    checks++;
    if ({busy0, 6'(q0.size())} !== 7'd0) begin
      failures++;
      $display("FAIL break_release got=busy%b/%0d exp=busy0/0", busy0, q0.size());
    end
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    wait_clk(20);
    e = (q0.size() == 1) ? q0.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b00, 8'h55}) begin
      failures++;
      $display("FAIL break_next_word got=%h exp=%h", e, {2'b00, 8'h55});
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic [9:0] e;
    d = 8'h81;
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, d[i]);
    drive(0, d[4]);
    wait_clk(SPB / 2);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({dv0, data0, pe0, fe0, busy0} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_out got=%h exp=000", {dv0, data0, pe0, fe0, busy0});
    end
    drive(0, 1'b1);
    wait_clk(20);
    n_rst = 1'b1;
    wait_clk(20);
    checks++;
    if (q0.size() !== 0) begin
      failures++;
      $display("FAIL midreset_pulses got=%0d exp=0", q0.size());
    end
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    wait_clk(20);
    e = (q0.size() == 1) ? q0.pop_front() : 10'h3FF;
    checks++;
    if (e !== {2'b00, 8'h81}) begin
      failures++;
      $display("FAIL midreset_next_word got=%h exp=%h", e, {2'b00, 8'h81});
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_break();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
